// File: rtl/spi_instr_pkg.sv
// Shared opcode constants, decoder state encoding and opcode classification helpers.
// No logic of its own; imported by the serial front-end modules.
// Backpressure: not applicable.
package spi_instr_pkg;

    localparam int OPCODE_BITS = 8;

    localparam logic [OPCODE_BITS-1:0] OP_WRSR      = 8'h01;
    localparam logic [OPCODE_BITS-1:0] OP_PP        = 8'h02;
    localparam logic [OPCODE_BITS-1:0] OP_READ      = 8'h03;
    localparam logic [OPCODE_BITS-1:0] OP_WRDI      = 8'h04;
    localparam logic [OPCODE_BITS-1:0] OP_RDSR      = 8'h05;
    localparam logic [OPCODE_BITS-1:0] OP_WREN      = 8'h06;
    localparam logic [OPCODE_BITS-1:0] OP_FAST_READ = 8'h0B;
    localparam logic [OPCODE_BITS-1:0] OP_RES       = 8'hAB;
    localparam logic [OPCODE_BITS-1:0] OP_DP        = 8'hB9;
    localparam logic [OPCODE_BITS-1:0] OP_BE        = 8'hC7;
    localparam logic [OPCODE_BITS-1:0] OP_SE        = 8'hD8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_RDOUT,
        ST_WAIT,
        ST_IGNORE
    } state_t;

    function automatic logic is_write_op(input logic [OPCODE_BITS-1:0] op);
        return op inside {OP_WREN, OP_WRDI, OP_WRSR, OP_PP, OP_SE, OP_BE, OP_DP};
    endfunction

    function automatic logic wel_exempt(input logic [OPCODE_BITS-1:0] op);
        return (op == OP_WREN) || (op == OP_WRDI);
    endfunction

endpackage

// File: rtl/spi_shift_in.sv
// MSB-first byte deserialiser with bit counter; byte_nxt/byte_done are combinational on the 8th bit.
// Latency: byte_done asserts in the same cycle the 8th bit is presented.
// Backpressure: en low (hold or deselect) freezes shift and count; clr realigns to a byte boundary.
module spi_shift_in
    import spi_instr_pkg::*;
(
    input  logic                   c,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   d,
    output logic [OPCODE_BITS-1:0] byte_nxt,
    output logic [2:0]             bit_cnt,
    output logic                   byte_done
);

    logic [OPCODE_BITS-2:0] sh;

    assign byte_nxt  = {sh, d};
    assign byte_done = en && (bit_cnt == 3'd7);

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            sh      <= '0;
            bit_cnt <= 3'd0;
        end else if (clr) begin
            sh      <= '0;
            bit_cnt <= 3'd0;
        end else if (en) begin
            sh      <= byte_nxt[OPCODE_BITS-2:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/spi_instr_decoder.sv
// SPI instruction decoder for the M25P10A model; FAST_READ_EN adds the 0B fast-read opcode.
// Latency: all qualifiers are registered and appear the cycle after the sampling edge of the completing bit.
// Backpressure: hold=0 freezes the decoder; write_op commits only at a clean, byte-aligned deselect.
module spi_instr_decoder
    import spi_instr_pkg::*;
#(
    parameter int ADDR_BITS     = 24,
    parameter int MEM_ADDR_BITS = 17,
    parameter int PAGE_BITS     = 8
) (
    input  logic                     c,
    input  logic                     rst_n,
    input  logic                     s,
    input  logic                     d,
    input  logic                     hold,
    input  logic                     wel,
    input  logic                     wip,
    input  logic                     status_srwd,
    output logic [OPCODE_BITS-1:0]   instr,
    output logic                     instr_valid,
    output logic [MEM_ADDR_BITS-1:0] addr,
    output logic [OPCODE_BITS-1:0]   data_byte,
    output logic                     data_valid,
    output logic                     read_op,
    output logic                     rdsr_op,
    output logic                     wrsr,
    output logic                     srwd_wrsr,
    output logic                     write_op
);

    localparam int ADDR_BYTES = ADDR_BITS / OPCODE_BITS;
    localparam int ACW        = $clog2(ADDR_BYTES + 1);

    state_t                   state, state_nxt;
    logic [OPCODE_BITS-1:0]   byte_nxt;
    logic [2:0]               bit_cnt;
    logic                     byte_done;
    logic                     active;
    logic [ACW-1:0]           addr_cnt;
    logic [MEM_ADDR_BITS-OPCODE_BITS-1:0] addr_acc;
    logic [MEM_ADDR_BITS-1:0] addr_full;
    logic                     data_seen;
    logic evt_instr, evt_addr, evt_addr_last, evt_data, evt_read, evt_rdsr, evt_wrsr, commit;

    assign active    = !s && hold;
    // Address bits above the array size simply fall off the top of this shifter.
    assign addr_full = {addr_acc, byte_nxt};

    spi_shift_in u_shift (
        .c         (c),
        .rst_n     (rst_n),
        .clr       (s),
        .en        (active),
        .d         (d),
        .byte_nxt  (byte_nxt),
        .bit_cnt   (bit_cnt),
        .byte_done (byte_done)
    );

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        evt_instr     = 1'b0;
        evt_addr      = 1'b0;
        evt_addr_last = 1'b0;
        evt_data      = 1'b0;
        evt_read      = 1'b0;
        evt_rdsr      = 1'b0;
        evt_wrsr      = 1'b0;
        commit        = 1'b0;
        if (s) begin
            state_nxt = ST_IDLE;
            commit    = (state == ST_WAIT || (state == ST_DATA && data_seen)) &&
                        (bit_cnt == 3'd0) && is_write_op(instr) && !wip &&
                        (wel || wel_exempt(instr));
        end else if (hold) begin
            case (state)
                ST_IDLE, ST_INSTR: begin
                    state_nxt = ST_INSTR;
                    if (byte_done) begin
                        evt_instr = 1'b1;
                        if (wip && byte_nxt != OP_RDSR) begin
                            state_nxt = ST_IGNORE;
                        end else begin
                            case (byte_nxt)
                                OP_WREN, OP_WRDI, OP_BE, OP_DP, OP_RES: state_nxt = ST_WAIT;
`ifdef FAST_READ_EN
                                OP_SE, OP_READ, OP_PP, OP_FAST_READ:    state_nxt = ST_ADDR;
`else
                                OP_SE, OP_READ, OP_PP:                  state_nxt = ST_ADDR;
`endif
                                OP_WRSR: begin
                                    state_nxt = ST_DATA;
                                    evt_wrsr  = 1'b1;
                                end
                                OP_RDSR: begin
                                    state_nxt = ST_RDOUT;
                                    evt_rdsr  = 1'b1;
                                end
                                default: state_nxt = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done) begin
                        evt_addr = 1'b1;
                        if (addr_cnt == ACW'(ADDR_BYTES - 1)) begin
                            evt_addr_last = 1'b1;
                            case (instr)
                                OP_READ: begin
                                    state_nxt = ST_RDOUT;
                                    evt_read  = 1'b1;
                                end
                                OP_PP:        state_nxt = ST_DATA;
`ifdef FAST_READ_EN
                                OP_FAST_READ: state_nxt = ST_DUMMY;
`endif
                                default:      state_nxt = ST_WAIT;
                            endcase
                        end
                    end
                end
                ST_DUMMY: begin
                    if (byte_done) begin
                        state_nxt = ST_RDOUT;
                        evt_read  = 1'b1;
                    end
                end
                ST_DATA: evt_data = byte_done;
                default: ;
            endcase
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            addr        <= '0;
            addr_acc    <= '0;
            addr_cnt    <= '0;
            data_byte   <= '0;
            data_valid  <= 1'b0;
            data_seen   <= 1'b0;
            read_op     <= 1'b0;
            rdsr_op     <= 1'b0;
            wrsr        <= 1'b0;
            srwd_wrsr   <= 1'b0;
            write_op    <= 1'b0;
        end else begin
            instr_valid <= evt_instr;
            data_valid  <= evt_data;
            write_op    <= commit;
            if (evt_instr) begin
                instr    <= byte_nxt;
                addr_cnt <= '0;
            end
            if (evt_addr) begin
                addr_acc <= addr_full[MEM_ADDR_BITS-OPCODE_BITS-1:0];
                addr_cnt <= addr_cnt + ACW'(1);
            end
            // PP addr advances the cycle after data_valid so consumers see the byte's own address.
            if (evt_addr_last)
                addr <= addr_full;
            else if (data_valid && instr == OP_PP)
                addr[PAGE_BITS-1:0] <= addr[PAGE_BITS-1:0] + PAGE_BITS'(1);
            if (evt_data) begin
                data_byte <= byte_nxt;
                data_seen <= 1'b1;
            end
            if (s) begin
                data_seen <= 1'b0;
                read_op   <= 1'b0;
                rdsr_op   <= 1'b0;
                wrsr      <= 1'b0;
                srwd_wrsr <= 1'b0;
            end else begin
                if (evt_read) read_op <= 1'b1;
                if (evt_rdsr) rdsr_op <= 1'b1;
                if (evt_wrsr) begin
                    wrsr      <= 1'b1;
                    srwd_wrsr <= status_srwd;
                end
            end
        end
    end

endmodule
